// File: rtl/dm_pkg.sv
// Debug-module shared types.
// Holds the lock-state encoding used by the system-bus access arbiter.
package dm_pkg;

  typedef enum logic {
    FREE   = 1'b0,
    LOCKED = 1'b1
  } sba_lock_e;

endpackage

// File: rtl/dm_sba_arb_idfifo.sv
// In-order FIFO of requester IDs.
// Records who owns each granted-but-unanswered bus transaction.
module dm_sba_arb_idfifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned IdW   = 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           push_i,
  input  logic [IdW-1:0] push_id_i,
  input  logic           pop_i,
  output logic [IdW-1:0] head_o,
  output logic           full_o,
  output logic           empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [IdW-1:0]  mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage needs no reset; count_q alone decides which entries are valid.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= push_id_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/dm_sba_arbiter.sv
// Round-robin arbiter sharing one system-bus master port between requesters,
// with a per-transaction lock and ID-FIFO routing of in-order responses.
module dm_sba_arbiter
  import dm_pkg::*;
#(
  parameter int unsigned BusWidth = 32,
  parameter int unsigned NumReq   = 2,
  parameter int unsigned MaxOutst = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NumReq-1:0]            req_i,
  input  logic [NumReq*BusWidth-1:0]   add_i,
  input  logic [NumReq-1:0]            we_i,
  input  logic [NumReq*BusWidth-1:0]   wdata_i,
  input  logic [NumReq*BusWidth/8-1:0] be_i,
  output logic [NumReq-1:0]            gnt_o,
  output logic [NumReq-1:0]            r_valid_o,
  output logic [BusWidth-1:0]          r_rdata_o,
  output logic                         master_req_o,
  output logic [BusWidth-1:0]          master_add_o,
  output logic                         master_we_o,
  output logic [BusWidth-1:0]          master_wdata_o,
  output logic [BusWidth/8-1:0]        master_be_o,
  input  logic                         master_gnt_i,
  input  logic                         master_r_valid_i,
  input  logic [BusWidth-1:0]          master_r_rdata_i,
  output logic                         unexp_rsp_o
);

  localparam int unsigned IdW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned BeW = BusWidth / 8;

  sba_lock_e      state_q, state_d;
  logic [IdW-1:0] owner_q, owner_d;
  logic [IdW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0] winner;
  logic           found;
  logic           handshake, pop;
  logic           fifo_full, fifo_empty;
  logic [IdW-1:0] fifo_head;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    winner = rr_ptr_q;
    found  = 1'b0;
    if (state_q == LOCKED) begin
      winner = owner_q;
    end else begin
      for (int k = 0; k < NumReq; k++) begin
        if (!found && req_i[(int'(rr_ptr_q) + k) % NumReq]) begin
          winner = IdW'((int'(rr_ptr_q) + k) % NumReq);
          found  = 1'b1;
        end
      end
    end
  end

  // A pop in the same cycle does not free a slot: fullness comes from the registered count.
  assign master_req_o   = !rst_i && req_i[winner] && !fifo_full;
  assign handshake      = master_req_o && master_gnt_i;
  assign master_add_o   = add_i[int'(winner)*BusWidth +: BusWidth];
  assign master_we_o    = we_i[winner];
  assign master_wdata_o = wdata_i[int'(winner)*BusWidth +: BusWidth];
  assign master_be_o    = be_i[int'(winner)*BeW +: BeW];

  assign pop         = !rst_i && master_r_valid_i && !fifo_empty;
  assign unexp_rsp_o = !rst_i && master_r_valid_i && fifo_empty;
  assign r_rdata_o   = master_r_rdata_i;

  always_comb begin
    gnt_o     = '0;
    r_valid_o = '0;
    if (handshake) gnt_o[winner]        = 1'b1;
    if (pop)       r_valid_o[fifo_head] = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    if (handshake) begin
      state_d  = FREE;
      rr_ptr_d = (winner == IdW'(NumReq - 1)) ? '0 : winner + IdW'(1);
    end else begin
      case (state_q)
        FREE: begin
          if (master_req_o) begin
            state_d = LOCKED;
            owner_d = winner;
          end
        end
        LOCKED: begin
          // Owner withdrew its request before being granted: release without a transfer.
          if (!req_i[owner_q]) state_d = FREE;
        end
        default: state_d = FREE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= FREE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  dm_sba_arb_idfifo #(
    .Depth (MaxOutst),
    .IdW   (IdW)
  ) i_idfifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (handshake),
    .push_id_i (winner),
    .pop_i     (pop),
    .head_o    (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

endmodule
